// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer for the single-cycle core.
// At each instruction boundary it looks for an enabled interrupt, a
// synchronous exception or an mret. On a trap it stalls the instruction,
// latches cause/epc/mtval, pulses the CSR update strobes (SAVE) and then
// redirects the PC to the handler (JUMP). An mret is a single MRET cycle
// that restores mstatus and redirects to mepc. Every output except the
// IDLE-state stall is decoded from the state register.

module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] inst_pc_i,
    input  logic            excp_illegal_i,
    input  logic            excp_ecall_i,
    input  logic            excp_ebreak_i,
    input  logic            excp_ld_misalign_i,
    input  logic            excp_st_misalign_i,
    input  logic [XLEN-1:0] excp_addr_i,
    input  logic            mret_i,
    input  logic            int_soft_i,
    input  logic            int_time_i,
    input  logic            int_exte_i,
    input  logic            csr_mstatus_MIE_i,
    input  logic            csr_mie_msie_i,
    input  logic            csr_mie_mtie_i,
    input  logic            csr_mie_meie_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    output logic            stall_o,
    output logic            cause_en_o,
    output logic            cause_int_o,
    output logic [3:0]      cause_code_o,
    output logic            epc_en_o,
    output logic [XLEN-1:0] epc_val_o,
    output logic            mtval_en_o,
    output logic [XLEN-1:0] mtval_val_o,
    output logic            mstatus_trap_o,
    output logic            mstatus_mret_o,
    output logic            redirect_en_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_JUMP = 2'd2,
        ST_MRET = 2'd3
    } state_e;

    // mcause exception / interrupt codes
    localparam logic [3:0] CODE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CODE_EBREAK   = 4'd3;
    localparam logic [3:0] CODE_LD_MIS   = 4'd4;
    localparam logic [3:0] CODE_ST_MIS   = 4'd6;
    localparam logic [3:0] CODE_ECALL    = 4'd11;
    localparam logic [3:0] CODE_IRQ_SOFT = 4'd3;
    localparam logic [3:0] CODE_IRQ_TIME = 4'd7;
    localparam logic [3:0] CODE_IRQ_EXTE = 4'd11;

    // Handler address: mtvec base, plus 4*code for vectored interrupts.
    function automatic logic [XLEN-1:0] handler_pc(
        input logic [XLEN-1:0] mtvec,
        input logic            is_int,
        input logic [3:0]      code
    );
        logic [XLEN-1:0] base;
        logic [XLEN-1:0] offs;
        base = {mtvec[XLEN-1:2], 2'b00};
        if ((mtvec[1:0] == 2'b01) && is_int) begin
            offs = {{(XLEN-6){1'b0}}, code, 2'b00};
        end else begin
            offs = {XLEN{1'b0}};
        end
        return base + offs;
    endfunction

    state_e          state_q, state_d;
    logic            int_q, int_d;
    logic [3:0]      code_q, code_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] mtval_q, mtval_d;

    logic            irq_exte_s, irq_soft_s, irq_time_s, irq_any_s;
    logic            excp_any_s;
    logic            at_boundary_s;
    logic            trap_det_s, mret_det_s;
    logic            det_int_s;
    logic [3:0]      det_code_s;
    logic [XLEN-1:0] det_mtval_s;
    logic [XLEN-1:0] jump_pc_s;

    // Event detection and cause prioritisation at the instruction boundary.
    always_comb begin
        irq_exte_s    = csr_mstatus_MIE_i & int_exte_i & csr_mie_meie_i;
        irq_soft_s    = csr_mstatus_MIE_i & int_soft_i & csr_mie_msie_i;
        irq_time_s    = csr_mstatus_MIE_i & int_time_i & csr_mie_mtie_i;
        irq_any_s     = irq_exte_s | irq_soft_s | irq_time_s;
        excp_any_s    = excp_illegal_i | excp_ecall_i | excp_ebreak_i |
                        excp_ld_misalign_i | excp_st_misalign_i;
        at_boundary_s = (state_q == ST_IDLE) & inst_valid_i;
        trap_det_s    = at_boundary_s & (irq_any_s | excp_any_s);
        mret_det_s    = at_boundary_s & mret_i & ~(irq_any_s | excp_any_s);

        det_int_s   = 1'b0;
        det_code_s  = 4'd0;
        det_mtval_s = {XLEN{1'b0}};
        if (irq_exte_s) begin
            det_int_s  = 1'b1;
            det_code_s = CODE_IRQ_EXTE;
        end else if (irq_soft_s) begin
            det_int_s  = 1'b1;
            det_code_s = CODE_IRQ_SOFT;
        end else if (irq_time_s) begin
            det_int_s  = 1'b1;
            det_code_s = CODE_IRQ_TIME;
        end else if (excp_illegal_i) begin
            det_code_s = CODE_ILLEGAL;
        end else if (excp_ecall_i) begin
            det_code_s = CODE_ECALL;
        end else if (excp_ebreak_i) begin
            det_code_s  = CODE_EBREAK;
            det_mtval_s = inst_pc_i;
        end else if (excp_ld_misalign_i) begin
            det_code_s  = CODE_LD_MIS;
            det_mtval_s = excp_addr_i;
        end else if (excp_st_misalign_i) begin
            det_code_s  = CODE_ST_MIS;
            det_mtval_s = excp_addr_i;
        end else begin
            det_code_s = 4'd0;
        end
    end

    // State and latched trap information registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            int_q   <= 1'b0;
            code_q  <= 4'd0;
            epc_q   <= {XLEN{1'b0}};
            mtval_q <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            mtval_q <= mtval_d;
        end
    end

    // Next-state and trap-latch logic; inputs are only sampled in IDLE.
    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        code_d  = code_q;
        epc_d   = epc_q;
        mtval_d = mtval_q;
        case (state_q)
            ST_IDLE: begin
                if (trap_det_s) begin
                    state_d = ST_SAVE;
                    int_d   = det_int_s;
                    code_d  = det_code_s;
                    epc_d   = inst_pc_i;
                    mtval_d = det_mtval_s;
                end else if (mret_det_s) begin
                    state_d = ST_MRET;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE: state_d = ST_JUMP;
            ST_JUMP: state_d = ST_IDLE;
            ST_MRET: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handler target computed from the live mtvec and the latched cause.
    always_comb begin
        jump_pc_s = handler_pc(csr_mtvec_i, int_q, code_q);
    end

    // Output decode: strobes and redirect from the state register only.
    always_comb begin
        stall_o        = 1'b0;
        cause_en_o     = 1'b0;
        cause_int_o    = 1'b0;
        cause_code_o   = 4'd0;
        epc_en_o       = 1'b0;
        epc_val_o      = {XLEN{1'b0}};
        mtval_en_o     = 1'b0;
        mtval_val_o    = {XLEN{1'b0}};
        mstatus_trap_o = 1'b0;
        mstatus_mret_o = 1'b0;
        redirect_en_o  = 1'b0;
        redirect_pc_o  = {XLEN{1'b0}};
        case (state_q)
            ST_IDLE: begin
                stall_o = trap_det_s | mret_det_s;
            end
            ST_SAVE: begin
                stall_o        = 1'b1;
                cause_en_o     = 1'b1;
                cause_int_o    = int_q;
                cause_code_o   = code_q;
                epc_en_o       = 1'b1;
                epc_val_o      = epc_q;
                mtval_en_o     = 1'b1;
                mtval_val_o    = mtval_q;
                mstatus_trap_o = 1'b1;
            end
            ST_JUMP: begin
                stall_o       = 1'b1;
                redirect_en_o = 1'b1;
                redirect_pc_o = jump_pc_s;
            end
            ST_MRET: begin
                stall_o        = 1'b1;
                mstatus_mret_o = 1'b1;
                redirect_en_o  = 1'b1;
                redirect_pc_o  = csr_mepc_i;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based reference model.

module tb_trap_ctrl;

    typedef struct packed {
        logic        stall;
        logic        cause_en;
        logic        cause_int;
        logic [3:0]  code;
        logic        epc_en;
        logic [31:0] epc;
        logic        mtval_en;
        logic [31:0] mtval;
        logic        mtrap;
        logic        mmret;
        logic        redir_en;
        logic [31:0] redir_pc;
    } out_t;

    logic        clk, rst_n;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        illegal, ecall, ebreak, ldm, stm;
    logic [31:0] addr;
    logic        mret;
    logic        isoft, itime, iexte;
    logic        mie, msie, mtie, meie;
    logic [31:0] mtvec, mepc;

    logic        stall_o, cause_en_o, cause_int_o;
    logic [3:0]  cause_code_o;
    logic        epc_en_o, mtval_en_o;
    logic [31:0] epc_val_o, mtval_val_o;
    logic        mstatus_trap_o, mstatus_mret_o, redirect_en_o;
    logic [31:0] redirect_pc_o;

    int n_checks = 0;
    int n_fail   = 0;
    out_t exp_q[$];

    trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid), .inst_pc_i(inst_pc),
        .excp_illegal_i(illegal), .excp_ecall_i(ecall), .excp_ebreak_i(ebreak),
        .excp_ld_misalign_i(ldm), .excp_st_misalign_i(stm), .excp_addr_i(addr),
        .mret_i(mret),
        .int_soft_i(isoft), .int_time_i(itime), .int_exte_i(iexte),
        .csr_mstatus_MIE_i(mie), .csr_mie_msie_i(msie), .csr_mie_mtie_i(mtie),
        .csr_mie_meie_i(meie),
        .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
        .stall_o(stall_o), .cause_en_o(cause_en_o), .cause_int_o(cause_int_o),
        .cause_code_o(cause_code_o), .epc_en_o(epc_en_o), .epc_val_o(epc_val_o),
        .mtval_en_o(mtval_en_o), .mtval_val_o(mtval_val_o),
        .mstatus_trap_o(mstatus_trap_o), .mstatus_mret_o(mstatus_mret_o),
        .redirect_en_o(redirect_en_o), .redirect_pc_o(redirect_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t pack_obs();
        out_t o;
        o.stall = stall_o;       o.cause_en = cause_en_o;  o.cause_int = cause_int_o;
        o.code = cause_code_o;   o.epc_en = epc_en_o;      o.epc = epc_val_o;
        o.mtval_en = mtval_en_o; o.mtval = mtval_val_o;    o.mtrap = mstatus_trap_o;
        o.mmret = mstatus_mret_o; o.redir_en = redirect_en_o; o.redir_pc = redirect_pc_o;
        return o;
    endfunction

    // Reference model: pending trap/mret cycles sit in a queue; when the
    // queue is empty the current instruction is judged from the rules.
    task automatic model_cycle(output out_t e);
        out_t s, j;
        int code;
        bit is_int;
        logic [31:0] tv;
        e = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else if (inst_valid) begin
            code = -1; is_int = 0; tv = 32'd0;
            if (mie && iexte && meie) code = 11;
            else if (mie && isoft && msie) code = 3;
            else if (mie && itime && mtie) code = 7;
            if (code >= 0) is_int = 1;
            else if (illegal) code = 2;
            else if (ecall) code = 11;
            else if (ebreak) begin code = 3; tv = inst_pc; end
            else if (ldm) begin code = 4; tv = addr; end
            else if (stm) begin code = 6; tv = addr; end
            if (code >= 0) begin
                e.stall = 1'b1;
                s = '0; s.stall = 1'b1; s.cause_en = 1'b1; s.cause_int = is_int;
                s.code = code[3:0]; s.epc_en = 1'b1; s.epc = inst_pc;
                s.mtval_en = 1'b1; s.mtval = tv; s.mtrap = 1'b1;
                j = '0; j.stall = 1'b1; j.redir_en = 1'b1;
                j.redir_pc = (mtvec & ~32'd3) +
                             (((mtvec % 4) == 1 && is_int) ? 32'(4 * code) : 32'd0);
                exp_q.push_back(s);
                exp_q.push_back(j);
            end else if (mret) begin
                e.stall = 1'b1;
                j = '0; j.stall = 1'b1; j.mmret = 1'b1; j.redir_en = 1'b1; j.redir_pc = mepc;
                exp_q.push_back(j);
            end
        end
    endtask

    task automatic clear_events();
        inst_valid = 1'b0; inst_pc = 32'd0; illegal = 1'b0; ecall = 1'b0;
        ebreak = 1'b0; ldm = 1'b0; stm = 1'b0; addr = 32'd0; mret = 1'b0;
        isoft = 1'b0; itime = 1'b0; iexte = 1'b0;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic eval(output out_t o, output out_t e);
        model_cycle(e);
        @(negedge clk);
        o = pack_obs();
    endtask

    task automatic test_reset();
        out_t o;
        o = pack_obs();
        n_checks++;
        if (o !== out_t'(0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", o);
        end
    endtask

    task automatic test_ecall();
        out_t o, e;
        mie = 1'b0; mtvec = 32'h200;
        for (int c = 0; c < 4; c++) begin
            advance();
            clear_events();
            if (c == 0) begin inst_valid = 1'b1; inst_pc = 32'h100; ecall = 1'b1; end
            if (c == 3) begin inst_valid = 1'b1; inst_pc = 32'h200; end
            eval(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL ecall_c%0d: got %h expected %h", c, o, e); end
            if (c == 1) begin
                n_checks++;
                if (o.code !== 4'd11 || o.cause_int !== 1'b0 || o.epc !== 32'h100 ||
                    o.mtval !== 32'd0 || o.mtrap !== 1'b1) begin
                    n_fail++; $display("FAIL ecall_save: got %h expected code b epc 100", o);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (o.redir_pc !== 32'h200 || o.redir_en !== 1'b1) begin
                    n_fail++; $display("FAIL ecall_redirect: got %h expected 200", o.redir_pc);
                end
            end
        end
    endtask

    task automatic test_priority_illegal();
        out_t o, e;
        for (int c = 0; c < 3; c++) begin
            advance();
            clear_events();
            if (c == 0) begin
                inst_valid = 1'b1; inst_pc = 32'h140; ldm = 1'b1; addr = 32'h1003; illegal = 1'b1;
            end
            eval(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL illegal_prio_c%0d: got %h expected %h", c, o, e); end
            if (c == 1) begin
                n_checks++;
                if (o.code !== 4'd2 || o.mtval !== 32'd0) begin
                    n_fail++; $display("FAIL illegal_wins: got code %0d mtval %h expected 2/0", o.code, o.mtval);
                end
            end
        end
    endtask

    task automatic test_irq_vectored();
        out_t o, e;
        mie = 1'b1; meie = 1'b1; mtie = 1'b1; msie = 1'b0; mtvec = 32'h301;
        for (int c = 0; c < 4; c++) begin
            advance();
            clear_events();
            if (c == 0) begin inst_valid = 1'b1; inst_pc = 32'h180; iexte = 1'b1; itime = 1'b1; end
            if (c == 3) begin mie = 1'b0; inst_valid = 1'b1; inst_pc = 32'h184; iexte = 1'b1; itime = 1'b1; end
            eval(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL irq_c%0d: got %h expected %h", c, o, e); end
            if (c == 2) begin
                n_checks++;
                if (o.redir_pc !== 32'h32C) begin
                    n_fail++; $display("FAIL irq_vector: got %h expected 32c", o.redir_pc);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (o.stall !== 1'b0) begin
                    n_fail++; $display("FAIL irq_masked_stall: got %b expected 0", o.stall);
                end
            end
        end
    endtask

    task automatic test_mret();
        out_t o, e;
        mie = 1'b0; mepc = 32'h104; mtvec = 32'h200;
        for (int c = 0; c < 5; c++) begin
            advance();
            clear_events();
            if (c == 0) begin inst_valid = 1'b1; inst_pc = 32'h210; mret = 1'b1; end
            if (c == 2) begin inst_valid = 1'b1; inst_pc = 32'h214; mret = 1'b1; ecall = 1'b1; end
            eval(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL mret_c%0d: got %h expected %h", c, o, e); end
            if (c == 1) begin
                n_checks++;
                if (o.mmret !== 1'b1 || o.redir_pc !== 32'h104 || o.redir_en !== 1'b1) begin
                    n_fail++; $display("FAIL mret_redirect: got %h expected 104", o.redir_pc);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (o.code !== 4'd11 || o.mmret !== 1'b0 || o.cause_en !== 1'b1) begin
                    n_fail++; $display("FAIL mret_vs_ecall: got %h expected ecall save", o);
                end
            end
        end
    endtask

    task automatic test_ebreak_irq_during_save();
        out_t o, e;
        mie = 1'b1; meie = 1'b1; mtvec = 32'h200;
        for (int c = 0; c < 6; c++) begin
            advance();
            clear_events();
            if (c == 0) begin inst_valid = 1'b1; inst_pc = 32'h80; ebreak = 1'b1; end
            if (c >= 1) iexte = 1'b1;
            if (c == 1 || c == 2 || c == 4) begin inst_valid = 1'b1; inst_pc = 32'h300; end
            eval(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL ebreak_irq_c%0d: got %h expected %h", c, o, e); end
            if (c == 1) begin
                n_checks++;
                if (o.mtval !== 32'h80 || o.code !== 4'd3 || o.cause_int !== 1'b0) begin
                    n_fail++; $display("FAIL ebreak_mtval: got %h expected 80", o.mtval);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (o.cause_int !== 1'b1 || o.code !== 4'd11 || o.epc !== 32'h300) begin
                    n_fail++; $display("FAIL irq_after_save: got %h expected int code b", o);
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            advance(); clear_events(); eval(o, e);
        end
    endtask

    task automatic test_reset_mid_jump();
        out_t o, e;
        mie = 1'b0; mtvec = 32'h200;
        advance(); clear_events(); inst_valid = 1'b1; inst_pc = 32'h120; ecall = 1'b1; eval(o, e);
        advance(); clear_events(); eval(o, e);
        advance(); clear_events();
        n_checks++;
        if (redirect_en_o !== 1'b1) begin
            n_fail++; $display("FAIL jump_before_reset: got %b expected 1", redirect_en_o);
        end
        rst_n = 1'b0;
        #1;
        o = pack_obs();
        exp_q.delete();
        n_checks++;
        if (o !== out_t'(0)) begin n_fail++; $display("FAIL reset_mid_jump: got %h expected 0", o); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        advance(); clear_events(); inst_valid = 1'b1; inst_pc = 32'h400; eval(o, e);
        n_checks++;
        if (o.stall !== 1'b0 || o !== e) begin
            n_fail++; $display("FAIL post_reset_stall: got %h expected %h", o, e);
        end
    endtask

    task automatic test_random();
        out_t o, e;
        mtvec = {$urandom_range(0, 32'h3FFF), 2'b00} | 32'($urandom_range(0, 1));
        mepc  = $urandom & ~32'd3;
        for (int c = 0; c < 3000; c++) begin
            advance();
            inst_valid = ($urandom_range(0, 3) != 0);
            inst_pc    = $urandom & ~32'd3;
            illegal    = ($urandom_range(0, 9) == 0);
            ecall      = ($urandom_range(0, 9) == 0);
            ebreak     = ($urandom_range(0, 9) == 0);
            ldm        = ($urandom_range(0, 9) == 0);
            stm        = ($urandom_range(0, 9) == 0);
            addr       = $urandom;
            mret       = ($urandom_range(0, 5) == 0);
            isoft      = ($urandom_range(0, 5) == 0);
            itime      = ($urandom_range(0, 5) == 0);
            iexte      = ($urandom_range(0, 5) == 0);
            mie        = $urandom_range(0, 1) != 0;
            msie       = $urandom_range(0, 1) != 0;
            mtie       = $urandom_range(0, 1) != 0;
            meie       = $urandom_range(0, 1) != 0;
            eval(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL random_c%0d: got %h expected %h", c, o, e); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_events();
        mie = 1'b0; msie = 1'b0; mtie = 1'b0; meie = 1'b0;
        mtvec = 32'd0; mepc = 32'd0;
        #23;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_ecall();
        test_priority_illegal();
        test_irq_vectored();
        test_mret();
        test_ebreak_irq_during_save();
        test_reset_mid_jump();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
